mem_stage: RTL and testbench

- Memory-access pipeline stage of the 16-bit CPU, sitting between EX and WB.
- Takes the EX result and runs a req/ack handshake with data memory for LW/SW.
- Registers instr, we, wb, ret_addr and nxt_PC into the MEM/WB pipeline register that feeds the WB stage.
- Stalls upstream while a memory transaction is outstanding.

---
 rtl/mem_stage_pkg.sv | 41 ++++
 rtl/mem_stage_if.sv | 17 +
 rtl/mem_stage_wb_reg.sv | 44 ++++
 rtl/mem_stage.sv | 154 +++++++++++++++
 tb/tb_mem_stage.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared opcode map, instruction field helpers and FSM encoding for the MEM stage.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
    OP_XOR  = 4'h4, OP_SHL  = 4'h5, OP_SHR  = 4'h6, OP_ADDI = 4'h7,
    OP_LUI  = 4'h8, OP_LW   = 4'h9, OP_SW   = 4'hA, OP_BEQ  = 4'hB,
    OP_BNE  = 4'hC, OP_JMP  = 4'hD, OP_CALL = 4'hE, OP_RET  = 4'hF
  } opcode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 8;

  function automatic opcode_e op_of(input logic [15:0] instr);
    return opcode_e'(instr[OP_MSB:OP_LSB]);
  endfunction

  function automatic logic [3:0] rd_of(input logic [15:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

  function automatic logic is_mem(input opcode_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // CALL writes the link register; branches, jumps, RET and SW write nothing.
  function automatic logic reg_we(input opcode_e op);
    case (op)
      OP_SW, OP_BEQ, OP_BNE, OP_JMP, OP_RET: return 1'b0;
      default:                                return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_stage_wb_reg.sv
// MEM/WB pipeline register: ld captures a new entry, clr drops valid and write enable.
module mem_wb_reg #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld,
  input  logic          clr,
  input  logic [15:0]   instr_d,
  input  logic          we_d,
  input  logic [DW-1:0] data_d,
  input  logic [15:0]   ret_addr_d,
  input  logic [15:0]   nxt_pc_d,
  output logic          valid_q,
  output logic [15:0]   instr_q,
  output logic          we_q,
  output logic [DW-1:0] data_q,
  output logic [15:0]   ret_addr_q,
  output logic [15:0]   nxt_pc_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
      ret_addr_q <= '0;
      nxt_pc_q   <= '0;
    end else if (ld) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_d;
      we_q       <= we_d;
      data_q     <= data_d;
      ret_addr_q <= ret_addr_d;
      nxt_pc_q   <= nxt_pc_d;
    end else if (clr) begin
      // Payload holds so WB sees stable values; only valid/we are killed.
      valid_q <= 1'b0;
      we_q    <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage between EX and WB: LW/SW req/ack handshake, upstream stall, MEM/WB register.
// Optional MEM_STAGE_TIMEOUT_EN aborts an access after TIMEOUT unacknowledged cycles.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic [15:0]   ex_instr,
  input  logic [DW-1:0] ex_alu,
  input  logic [DW-1:0] ex_sdata,
  input  logic [15:0]   ex_ret_addr,
  input  logic [15:0]   ex_nxt_PC,
  output logic          stall,
  mem_stage_if.master   mem,
  output logic          wb_valid,
  output logic [15:0]   wb_instr,
  output logic          wb_we,
  output logic [DW-1:0] wb_data,
  output logic [15:0]   wb_ret_addr,
  output logic [15:0]   wb_nxt_PC,
  output logic          mem_err
);

  state_e        state, state_nxt;
  opcode_e       ex_op;
  logic          accept;
  logic          timeout_hit;
  logic [15:0]   lat_instr, lat_ret, lat_nxt;
  logic          ld, clr;
  logic [15:0]   d_instr, d_ret, d_nxt;
  logic          d_we;
  logic [DW-1:0] d_data;

  assign ex_op  = op_of(ex_instr);
  assign accept = (state == ST_IDLE) && ex_valid && is_mem(ex_op);
  assign stall  = (state == ST_ACCESS);

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    clr       = 1'b0;
    d_instr   = ex_instr;
    d_we      = 1'b0;
    d_data    = ex_alu;
    d_ret     = ex_ret_addr;
    d_nxt     = ex_nxt_PC;
    case (state)
      ST_IDLE: begin
        if (!ex_valid) begin
          clr = 1'b1;
        end else if (is_mem(ex_op)) begin
          clr       = 1'b1;
          state_nxt = ST_ACCESS;
        end else begin
          ld   = 1'b1;
          d_we = reg_we(ex_op);
        end
      end
      ST_ACCESS: begin
        d_instr = lat_instr;
        d_ret   = lat_ret;
        d_nxt   = lat_nxt;
        d_data  = '0;
        // Ack takes priority over the timeout abort on the same cycle.
        if (mem.mem_ack) begin
          ld        = 1'b1;
          state_nxt = ST_IDLE;
          if (op_of(lat_instr) == OP_LW) begin
            d_we   = 1'b1;
            d_data = mem.mem_rdata;
          end
        end else if (timeout_hit) begin
          ld        = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          clr = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      lat_instr     <= '0;
      lat_ret       <= '0;
      lat_nxt       <= '0;
    end else begin
      state       <= state_nxt;
      mem.mem_req <= (state_nxt == ST_ACCESS);
      if (accept) begin
        mem.mem_we    <= (ex_op == OP_SW);
        mem.mem_addr  <= AW'(ex_alu);
        mem.mem_wdata <= ex_sdata;
        lat_instr     <= ex_instr;
        lat_ret       <= ex_ret_addr;
        lat_nxt       <= ex_nxt_PC;
      end
    end
  end

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);
  logic [3:0] wait_cnt;

  assign timeout_hit = (state == ST_ACCESS) && (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (accept)
        wait_cnt <= '0;
      else if ((state == ST_ACCESS) && !mem.mem_ack)
        wait_cnt <= wait_cnt + 4'd1;
      if (timeout_hit && !mem.mem_ack)
        mem_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  mem_wb_reg #(.DW(DW)) u_mem_wb_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld         (ld),
    .clr        (clr),
    .instr_d    (d_instr),
    .we_d       (d_we),
    .data_d     (d_data),
    .ret_addr_d (d_ret),
    .nxt_pc_d   (d_nxt),
    .valid_q    (wb_valid),
    .instr_q    (wb_instr),
    .we_q       (wb_we),
    .data_q     (wb_data),
    .ret_addr_q (wb_ret_addr),
    .nxt_pc_q   (wb_nxt_PC)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized instruction stream.
module tb_mem_stage;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam logic [3:0] ADD = 4'd0, LW = 4'd9, SW = 4'd10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic ex_valid;
  logic [15:0] ex_instr, ex_alu, ex_sdata, ex_ret_addr, ex_nxt_PC;
  logic stall, wb_valid, wb_we, mem_err;
  logic [15:0] wb_instr, wb_data, wb_ret_addr, wb_nxt_PC;

  mem_stage_if #(.DW(DW), .AW(AW)) mbus ();

  mem_stage #(.DW(DW), .AW(AW), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_instr(ex_instr),
    .ex_alu(ex_alu), .ex_sdata(ex_sdata), .ex_ret_addr(ex_ret_addr),
    .ex_nxt_PC(ex_nxt_PC), .stall(stall), .mem(mbus),
    .wb_valid(wb_valid), .wb_instr(wb_instr), .wb_we(wb_we), .wb_data(wb_data),
    .wb_ret_addr(wb_ret_addr), .wb_nxt_PC(wb_nxt_PC), .mem_err(mem_err)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          stall_cyc;
    bit          hold_bad;
    logic        req1, we1;
    logic [15:0] addr1, wdata1;
    logic        vld, we, stall_after, req_after;
    logic [15:0] instr, data, ret, nxt;
  } obs_t;

  // Presents one instruction, serves its memory access with `lat` ACCESS cycles
  // (ack in the last), and snapshots what the stage showed along the way.
  task automatic exec(input logic [15:0] ins, alu, sd, ra, np,
                      input int lat, input logic [15:0] rd, output obs_t o);
    o = '{default: 0};
    ex_valid = 1'b1; ex_instr = ins; ex_alu = alu; ex_sdata = sd;
    ex_ret_addr = ra; ex_nxt_PC = np;
    @(posedge clk); @(negedge clk);
    if (ins[15:12] == LW || ins[15:12] == SW) begin
      o.req1 = mbus.mem_req; o.addr1 = mbus.mem_addr;
      o.we1 = mbus.mem_we; o.wdata1 = mbus.mem_wdata;
      for (int c = 1; c <= lat; c++) begin
        if (stall === 1'b1) o.stall_cyc++;
        if (mbus.mem_req !== 1'b1 || mbus.mem_addr !== o.addr1 || mbus.mem_we !== o.we1 ||
            mbus.mem_wdata !== o.wdata1 || wb_valid !== 1'b0) o.hold_bad = 1'b1;
        ex_instr = 16'($urandom); ex_alu = 16'($urandom);
        ex_sdata = 16'($urandom); ex_ret_addr = 16'($urandom); ex_nxt_PC = 16'($urandom);
        mbus.mem_rdata = (c == lat) ? rd : 16'($urandom);
        mbus.mem_ack = (c == lat);
        @(posedge clk); @(negedge clk);
      end
      mbus.mem_ack = 1'b0;
    end
    o.vld = wb_valid; o.we = wb_we; o.instr = wb_instr; o.data = wb_data;
    o.ret = wb_ret_addr; o.nxt = wb_nxt_PC; o.stall_after = stall; o.req_after = mbus.mem_req;
    ex_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    ex_valid = 1'b0;
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0; ex_valid = 1'b1; ex_instr = {ADD, 12'h123}; ex_alu = 16'h5555;
    ex_sdata = 16'h0; ex_ret_addr = 16'h1; ex_nxt_PC = 16'h2;
    mbus.mem_ack = 1'b0; mbus.mem_rdata = 16'h0;
    @(negedge clk); @(posedge clk); @(negedge clk);
    n_vec++;
    if ({wb_valid, wb_we, wb_instr, wb_data, wb_ret_addr, wb_nxt_PC} !== '0) begin
      n_err++; $display("FAIL reset_wb: got v=%b we=%b i=%h d=%h r=%h n=%h want all 0",
        wb_valid, wb_we, wb_instr, wb_data, wb_ret_addr, wb_nxt_PC);
    end
    n_vec++;
    if ({mbus.mem_req, mbus.mem_we, mbus.mem_addr, mbus.mem_wdata, stall, mem_err} !== '0) begin
      n_err++; $display("FAIL reset_mem: got req=%b we=%b a=%h wd=%h stall=%b err=%b want all 0",
        mbus.mem_req, mbus.mem_we, mbus.mem_addr, mbus.mem_wdata, stall, mem_err);
    end
    rst_n = 1'b1;
    exec({ADD, 12'h321}, 16'h1234, 16'h0, 16'hAAAA, 16'h0102, 0, 16'h0, o);
    n_vec++;
    if (o.vld !== 1'b1 || o.we !== 1'b1 || o.data !== 16'h1234 || o.instr !== {ADD, 12'h321} ||
        o.ret !== 16'hAAAA || o.nxt !== 16'h0102 || o.stall_after !== 1'b0) begin
      n_err++; $display("FAIL reset_add: got v=%b we=%b d=%h i=%h r=%h n=%h st=%b want 1 1 1234 0321 aaaa 0102 0",
        o.vld, o.we, o.data, o.instr, o.ret, o.nxt, o.stall_after);
    end
  endtask

  task automatic test_lw();
    obs_t o;
    exec({LW, 12'h300}, 16'h0040, 16'h7777, 16'h0011, 16'h0022, 3, 16'hBEEF, o);
    n_vec++;
    if (o.req1 !== 1'b1 || o.addr1 !== 16'h0040 || o.we1 !== 1'b0 || o.hold_bad) begin
      n_err++; $display("FAIL lw_req: got req=%b a=%h we=%b hold_bad=%b want 1 0040 0 0",
        o.req1, o.addr1, o.we1, o.hold_bad);
    end
    n_vec++;
    if (o.stall_cyc != 3) begin
      n_err++; $display("FAIL lw_stall: got %0d stall cycles want 3", o.stall_cyc);
    end
    n_vec++;
    if (o.vld !== 1'b1 || o.we !== 1'b1 || o.data !== 16'hBEEF || o.instr !== {LW, 12'h300} ||
        o.ret !== 16'h0011 || o.nxt !== 16'h0022 || o.stall_after !== 1'b0 || o.req_after !== 1'b0) begin
      n_err++; $display("FAIL lw_wb: got v=%b we=%b d=%h i=%h r=%h n=%h st=%b req=%b want 1 1 beef 9300 0011 0022 0 0",
        o.vld, o.we, o.data, o.instr, o.ret, o.nxt, o.stall_after, o.req_after);
    end
  endtask

  task automatic test_sw();
    obs_t o;
    exec({SW, 12'h500}, 16'h0010, 16'h00AA, 16'h0, 16'h0, 1, 16'hFFFF, o);
    n_vec++;
    if (o.req1 !== 1'b1 || o.we1 !== 1'b1 || o.addr1 !== 16'h0010 || o.wdata1 !== 16'h00AA ||
        o.stall_cyc != 1) begin
      n_err++; $display("FAIL sw_req: got req=%b we=%b a=%h wd=%h stalls=%0d want 1 1 0010 00aa 1",
        o.req1, o.we1, o.addr1, o.wdata1, o.stall_cyc);
    end
    n_vec++;
    if (o.vld !== 1'b1 || o.we !== 1'b0 || o.data !== 16'h0000) begin
      n_err++; $display("FAIL sw_wb: got v=%b we=%b d=%h want 1 0 0000", o.vld, o.we, o.data);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2, o3;
    exec({LW, 12'h100}, 16'h0100, 16'h0, 16'h0, 16'h0, 2, 16'h1111, o1);
    exec({LW, 12'h200}, 16'h0200, 16'h0, 16'h0, 16'h0, 1, 16'h2222, o2);
    exec({ADD, 12'h300}, 16'h0ABC, 16'h0, 16'h0, 16'h0, 0, 16'h0, o3);
    n_vec++;
    if (o1.data !== 16'h1111 || o1.instr !== {LW, 12'h100} || o1.vld !== 1'b1 ||
        o2.data !== 16'h2222 || o2.instr !== {LW, 12'h200} || o2.vld !== 1'b1 || o2.stall_cyc != 1) begin
      n_err++; $display("FAIL b2b_lw: got d1=%h i1=%h d2=%h i2=%h st2=%0d want 1111 9100 2222 9200 1",
        o1.data, o1.instr, o2.data, o2.instr, o2.stall_cyc);
    end
    n_vec++;
    if (o3.vld !== 1'b1 || o3.we !== 1'b1 || o3.data !== 16'h0ABC) begin
      n_err++; $display("FAIL b2b_add: got v=%b we=%b d=%h want 1 1 0abc", o3.vld, o3.we, o3.data);
    end
  endtask

  task automatic test_idle_ack();
    ex_valid = 1'b0; mbus.mem_ack = 1'b1; mbus.mem_rdata = 16'hDEAD;
    @(posedge clk); @(negedge clk);
    mbus.mem_ack = 1'b0;
    n_vec++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0 || mbus.mem_req !== 1'b0 || stall !== 1'b0 ||
        wb_data !== 16'h0ABC || wb_instr !== {ADD, 12'h300}) begin
      n_err++; $display("FAIL idle_ack: got v=%b we=%b req=%b st=%b d=%h i=%h want 0 0 0 0 0abc 0300",
        wb_valid, wb_we, mbus.mem_req, stall, wb_data, wb_instr);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    logic req_before, req_during, vld_seen;
    ex_valid = 1'b1; ex_instr = {LW, 12'h400}; ex_alu = 16'h0080;
    @(posedge clk); @(negedge clk);
    ex_valid = 1'b0;
    req_before = mbus.mem_req;
    #2 rst_n = 1'b0;
    #1 req_during = mbus.mem_req;
    vld_seen = wb_valid;
    @(posedge clk); @(negedge clk);
    vld_seen |= wb_valid;
    rst_n = 1'b1;
    idle(1);
    vld_seen |= wb_valid;
    n_vec++;
    if (req_before !== 1'b1 || req_during !== 1'b0 || vld_seen !== 1'b0 || stall !== 1'b0) begin
      n_err++; $display("FAIL rst_mid: got req_before=%b req_in_rst=%b wb_valid_seen=%b st=%b want 1 0 0 0",
        req_before, req_during, vld_seen, stall);
    end
    exec({ADD, 12'h500}, 16'h4321, 16'h0, 16'h0, 16'h0, 0, 16'h0, o);
    n_vec++;
    if (o.vld !== 1'b1 || o.we !== 1'b1 || o.data !== 16'h4321) begin
      n_err++; $display("FAIL rst_mid_add: got v=%b we=%b d=%h want 1 1 4321", o.vld, o.we, o.data);
    end
  endtask

  // Reference: opcodes that write a register are all but SW, BEQ, BNE, JMP, RET.
  task automatic test_random();
    obs_t o;
    logic [15:0] wr_mask = 16'h43FF;
    for (int k = 0; k < 60; k++) begin
      logic [3:0]  op  = 4'($urandom_range(15));
      logic [15:0] ins = {op, 12'($urandom)};
      logic [15:0] alu = 16'($urandom), sd = 16'($urandom), rd = 16'($urandom);
      logic [15:0] ra = 16'($urandom), np = 16'($urandom);
      int          lat = $urandom_range(1, 5);
      logic        is_m = (op == LW) || (op == SW);
      logic        e_we = (op == LW) ? 1'b1 : (op == SW) ? 1'b0 : wr_mask[op];
      logic [15:0] e_d  = (op == LW) ? rd : (op == SW) ? 16'h0 : alu;
      exec(ins, alu, sd, ra, np, lat, rd, o);
      n_vec++;
      if (o.vld !== 1'b1 || o.we !== e_we || o.data !== e_d || o.instr !== ins ||
          o.ret !== ra || o.nxt !== np || (is_m && (o.stall_cyc != lat || o.hold_bad ||
          o.addr1 !== alu || o.we1 !== (op == SW) || o.wdata1 !== sd))) begin
        n_err++; $display("FAIL rand[%0d] op=%h: got v=%b we=%b d=%h i=%h r=%h n=%h st=%0d hb=%b want we=%b d=%h i=%h r=%h n=%h st=%0d",
          k, op, o.vld, o.we, o.data, o.instr, o.ret, o.nxt, o.stall_cyc, o.hold_bad,
          e_we, e_d, ins, ra, np, is_m ? lat : 0);
      end
      if ($urandom_range(3) == 0) begin
        idle(1);
        n_vec++;
        if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_instr !== ins) begin
          n_err++; $display("FAIL rand_gap[%0d]: got v=%b we=%b i=%h want 0 0 %h", k, wb_valid, wb_we, wb_instr, ins);
        end
      end
    end
    n_vec++;
    if (mem_err !== 1'b0) begin
      n_err++; $display("FAIL rand_err: got mem_err=%b want 0", mem_err);
    end
  endtask

`ifdef MEM_STAGE_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    int stalls = 0;
    ex_valid = 1'b1; ex_instr = {LW, 12'h600}; ex_alu = 16'h00F0;
    mbus.mem_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    ex_valid = 1'b0;
    for (int c = 0; c < 40 && stall === 1'b1; c++) begin
      stalls++;
      @(posedge clk); @(negedge clk);
    end
    n_vec++;
    if (stalls != 15 || stall !== 1'b0 || mem_err !== 1'b1 || wb_valid !== 1'b1 ||
        wb_we !== 1'b0 || mbus.mem_req !== 1'b0) begin
      n_err++; $display("FAIL timeout: got stalls=%0d st=%b err=%b v=%b we=%b req=%b want 15 0 1 1 0 0",
        stalls, stall, mem_err, wb_valid, wb_we, mbus.mem_req);
    end
    exec({ADD, 12'h700}, 16'h5A5A, 16'h0, 16'h0, 16'h0, 0, 16'h0, o);
    n_vec++;
    if (o.vld !== 1'b1 || o.we !== 1'b1 || o.data !== 16'h5A5A || mem_err !== 1'b1) begin
      n_err++; $display("FAIL timeout_add: got v=%b we=%b d=%h err=%b want 1 1 5a5a 1",
        o.vld, o.we, o.data, mem_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_back_to_back();
    test_idle_ack();
    test_reset_mid();
    test_random();
`ifdef MEM_STAGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
